// File: rtl/umem_arbiter.sv
// -----------------------------------------------------------------------------
// umem_arbiter
//
// Round-robin arbiter that shares one unified memory port between N_REQ cache
// hierarchies. The winner owns the memory port until its transaction completes
// or it withdraws. A one-cycle HOLD gap follows every completion so the memory
// sees its enables deassert. With LOCK_EN set, the owner can chain up to
// MAX_CHAIN follow-on transactions, such as the fill after an evict, without
// another requester getting in between.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   req_re_i     per-requester line read request (level, held until req_rdy_o)
//   req_we_i     per-requester line write request (level, held until req_rdy_o)
//   req_addr_i   flattened requester addresses, requester i at [i*AW +: AW]
//   req_wdata_i  flattened requester write lines, requester i at [i*DW +: DW]
//   req_rdy_o    one-cycle completion pulse, owner bit only
//   req_rdata_o  read line broadcast, valid only alongside req_rdy_o
//   gnt_o        registered one-hot owner, zero when idle
//   u_addr_o     unified memory address
//   u_re_o       unified memory read enable
//   u_we_o       unified memory write enable
//   u_wdata_o    unified memory write line
//   u_rd_data_i  unified memory read line
//   u_rdy_i      unified memory completion pulse
// -----------------------------------------------------------------------------
module umem_arbiter #(
    parameter int N_REQ     = 2,
    parameter int AW        = 11,
    parameter int DW        = 64,
    parameter int LOCK_EN   = 1,
    parameter int MAX_CHAIN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_re_i,
    input  logic [N_REQ-1:0]      req_we_i,
    input  logic [N_REQ*AW-1:0]   req_addr_i,
    input  logic [N_REQ*DW-1:0]   req_wdata_i,
    output logic [N_REQ-1:0]      req_rdy_o,
    output logic [DW-1:0]         req_rdata_o,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [AW-1:0]         u_addr_o,
    output logic                  u_re_o,
    output logic                  u_we_o,
    output logic [DW-1:0]         u_wdata_o,
    input  logic [DW-1:0]         u_rd_data_i,
    input  logic                  u_rdy_i
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CHAIN_MAX = CW'(MAX_CHAIN);

    logic [1:0]       state_q,  state_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [IW-1:0]    own_q,    own_d;     // binary index mirroring gnt_q
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    chain_q,  chain_d;

    logic [N_REQ-1:0] act_s;
    logic             own_re_s;
    logic             own_we_s;
    logic             own_act_s;
    logic [AW-1:0]    own_addr_s;
    logic [DW-1:0]    own_wdata_s;
    logic [IW-1:0]    pick_ptr_s;
    logic [IW:0]      pick_s;
    logic             pick_found_s;
    logic [IW-1:0]    pick_idx_s;
    logic             lock_s;

    // Increment a requester index modulo N_REQ.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        logic [IW-1:0] r;
        if (int'(i) >= N_REQ - 1) begin
            r = '0;
        end else begin
            r = i + IW'(1);
        end
        return r;
    endfunction

    // First active requester at or after ptr, searching upward with wrap.
    // Returns {found, index}. Walking the offsets downward lets the smallest
    // offset be the final assignment.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] act,
                                            input logic [IW-1:0]    ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (act[idx]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    assign act_s       = req_re_i | req_we_i;
    assign own_re_s    = req_re_i[own_q];
    assign own_we_s    = req_we_i[own_q];
    assign own_act_s   = own_re_s | own_we_s;
    assign own_addr_s  = req_addr_i[own_q*AW +: AW];
    assign own_wdata_s = req_wdata_i[own_q*DW +: DW];

    // In HOLD a release re-arbitrates in the same cycle from the pointer it
    // is about to store, so the search starts just past the current owner.
    assign pick_ptr_s   = (state_q == S_HOLD) ? next_idx(own_q) : rr_ptr_q;
    assign pick_s       = rr_pick(act_s, pick_ptr_s);
    assign pick_found_s = pick_s[IW];
    assign pick_idx_s   = pick_s[IW-1:0];

    assign lock_s = (LOCK_EN != 0) && (chain_q < CHAIN_MAX) && own_act_s;

    assign gnt_o = gnt_q;

    // Next-state logic for the grant FSM, pointer and chain counter.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        chain_d  = chain_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_d = S_BUSY;
                    own_d   = pick_idx_s;
                    gnt_d   = ONE_HOT0 << pick_idx_s;
                    chain_d = '0;
                end else begin
                    gnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (u_rdy_i) begin
                    state_d = S_HOLD;
                end else if (!own_act_s) begin
                    // Owner withdrew before completion: release, no pulse.
                    state_d  = S_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = next_idx(own_q);
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_HOLD: begin
                if (lock_s) begin
                    // Chained transaction keeps the owner and the pointer.
                    state_d = S_BUSY;
                    chain_d = chain_q + CW'(1);
                end else begin
                    rr_ptr_d = next_idx(own_q);
                    if (pick_found_s) begin
                        state_d = S_BUSY;
                        own_d   = pick_idx_s;
                        gnt_d   = ONE_HOT0 << pick_idx_s;
                        chain_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                chain_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            own_q    <= '0;
            rr_ptr_q <= '0;
            chain_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            own_q    <= own_d;
            rr_ptr_q <= rr_ptr_d;
            chain_q  <= chain_d;
        end
    end

    // Memory-side mux from the owner's live request and the completion path.
    always_comb begin
        u_re_o      = 1'b0;
        u_we_o      = 1'b0;
        u_addr_o    = '0;
        u_wdata_o   = '0;
        req_rdy_o   = '0;
        req_rdata_o = '0;
        if (gnt_q != '0) begin
            u_addr_o  = own_addr_s;
            u_wdata_o = own_wdata_s;
        end else begin
            u_addr_o  = '0;
            u_wdata_o = '0;
        end
        if (state_q == S_BUSY) begin
            // Write wins when a requester raises both enables.
            u_we_o = own_we_s;
            u_re_o = own_re_s & ~own_we_s;
            if (u_rdy_i) begin
                req_rdy_o   = gnt_q;
                req_rdata_o = u_rd_data_i;
            end else begin
                req_rdy_o   = '0;
                req_rdata_o = '0;
            end
        end else begin
            u_re_o = 1'b0;
            u_we_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_umem_arbiter
//
// Two arbiter instances: inst 0 uses N_REQ=2 with the lock enabled, and inst 1
// uses N_REQ=4 with the lock disabled. A small memory responder per instance
// answers each enable with u_rdy after a set latency. Expected memory
// operations and expected completions are queued when stimulus is applied. A
// monitor pops and compares them whenever the DUT starts a memory operation or
// pulses req_rdy.
// -----------------------------------------------------------------------------
module tb_umem_arbiter;

    localparam int AW = 11;
    localparam int DW = 64;

    typedef struct packed {
        logic [3:0]    gnt;
        logic [AW-1:0] addr;
        logic          re;
        logic          we;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct packed {
        logic [3:0]    rdy;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      a_re, a_we;
    logic [2*AW-1:0] a_addr;
    logic [2*DW-1:0] a_wdata;
    logic [3:0]      b_re, b_we;
    logic [4*AW-1:0] b_addr;
    logic [4*DW-1:0] b_wdata;
    wire  [1:0]      a_rdy, a_gnt;
    wire  [3:0]      b_rdy, b_gnt;

    logic [DW-1:0] mrd  [2];
    logic          mrdy [2];

    logic [3:0]    v_rdy   [2];
    logic [3:0]    v_gnt   [2];
    logic [AW-1:0] v_addr  [2];
    logic          v_re    [2];
    logic          v_we    [2];
    logic [DW-1:0] v_wd    [2];
    logic [DW-1:0] v_rdata [2];

    assign v_rdy[0] = {2'b00, a_rdy};
    assign v_rdy[1] = b_rdy;
    assign v_gnt[0] = {2'b00, a_gnt};
    assign v_gnt[1] = b_gnt;

    umem_arbiter #(.N_REQ(2), .AW(AW), .DW(DW), .LOCK_EN(1), .MAX_CHAIN(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_re_i(a_re), .req_we_i(a_we), .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .req_rdy_o(a_rdy), .req_rdata_o(v_rdata[0]), .gnt_o(a_gnt),
        .u_addr_o(v_addr[0]), .u_re_o(v_re[0]), .u_we_o(v_we[0]), .u_wdata_o(v_wd[0]),
        .u_rd_data_i(mrd[0]), .u_rdy_i(mrdy[0])
    );

    umem_arbiter #(.N_REQ(4), .AW(AW), .DW(DW), .LOCK_EN(0), .MAX_CHAIN(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_re_i(b_re), .req_we_i(b_we), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .req_rdy_o(b_rdy), .req_rdata_o(v_rdata[1]), .gnt_o(b_gnt),
        .u_addr_o(v_addr[1]), .u_re_o(v_re[1]), .u_we_o(v_we[1]), .u_wdata_o(v_wd[1]),
        .u_rd_data_i(mrd[1]), .u_rdy_i(mrdy[1])
    );

    int checks = 0;
    int errors = 0;

    op_t  opq0[$], opq1[$];
    rsp_t rq0[$],  rq1[$];

    int            m_lat  [2];
    int            m_cnt  [2];
    logic          m_busy [2];
    logic          m_fire [2];
    logic [AW-1:0] m_addr [2];

    // Memory contents seen by the bench: a fixed pattern derived from the address.
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {16'h5A5A, 5'h00, a, 21'h000000, a};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_op(input int k, input logic [3:0] g, input logic [AW-1:0] ad,
                           input logic r, input logic w, input logic [DW-1:0] wd);
        op_t o;
        o = '{gnt: g, addr: ad, re: r, we: w, wdata: wd};
        if (k == 0) opq0.push_back(o);
        else        opq1.push_back(o);
    endtask

    task automatic push_rsp(input int k, input logic [3:0] rdy, input logic [AW-1:0] ad);
        rsp_t e;
        e = '{rdy: rdy, rdata: mem_data(ad)};
        if (k == 0) rq0.push_back(e);
        else        rq1.push_back(e);
    endtask

    task automatic pop_op(input int k, output logic have, output op_t o);
        have = 1'b0;
        o    = '0;
        if (k == 0) begin
            if (opq0.size() > 0) begin o = opq0.pop_front(); have = 1'b1; end
        end else begin
            if (opq1.size() > 0) begin o = opq1.pop_front(); have = 1'b1; end
        end
    endtask

    task automatic pop_rsp(input int k, output logic have, output rsp_t e);
        have = 1'b0;
        e    = '0;
        if (k == 0) begin
            if (rq0.size() > 0) begin e = rq0.pop_front(); have = 1'b1; end
        end else begin
            if (rq1.size() > 0) begin e = rq1.pop_front(); have = 1'b1; end
        end
    endtask

    task automatic set_req(input int k, input int i, input logic r, input logic w,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (k == 0) begin
            a_re[i] = r; a_we[i] = w;
            a_addr[i*AW +: AW] = ad; a_wdata[i*DW +: DW] = wd;
        end else begin
            b_re[i] = r; b_we[i] = w;
            b_addr[i*AW +: AW] = ad; b_wdata[i*DW +: DW] = wd;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for req_rdy[i] on instance k, then return just after the next
    // rising edge, which is the first cycle of HOLD.
    task automatic wait_rdy(input int k, input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!v_rdy[k][i] && n < 100);
        checks++;
        if (!v_rdy[k][i]) begin
            errors++;
            $display("FAIL wait_rdy: inst %0d req %0d got no req_rdy within %0d cycles", k, i, n);
        end
        @(posedge clk);
        #1;
    endtask

    // Responder output: u_rdy and read data change just after the rising edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            mrdy[k]   = 1'b0;
            mrd[k]    = '0;
            m_fire[k] = 1'b0;
            m_busy[k] = 1'b0;
            m_cnt[k]  = 0;
            m_addr[k] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                mrdy[k]   = m_fire[k];
                mrd[k]    = m_fire[k] ? mem_data(m_addr[k]) : 64'h0;
                m_fire[k] = 1'b0;
            end
        end
    end

    // Monitor and responder bookkeeping on the falling edge.
    initial begin
        logic have;
        op_t  eo;
        rsp_t er;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst) begin
                    if (v_rdy[k] != 4'h0) begin
                        pop_rsp(k, have, er);
                        checks++;
                        if (!have) begin
                            errors++;
                            $display("FAIL unexpected_rdy: inst %0d req_rdy %b with nothing expected", k, v_rdy[k]);
                        end else begin
                            chk($sformatf("rsp_rdy%0d", k), 64'(v_rdy[k]), 64'(er.rdy));
                            chk($sformatf("rsp_rdata%0d", k), v_rdata[k], er.rdata);
                        end
                    end
                    chk($sformatf("rdy_owner%0d", k),
                        64'(((v_rdy[k] & ~v_gnt[k]) == 4'h0) && $onehot0(v_rdy[k])), 64'h1);
                    chk($sformatf("en_excl%0d", k), 64'(v_re[k] & v_we[k]), 64'h0);
                    if (v_gnt[k] == 4'h0) begin
                        chk($sformatf("idle_port%0d", k),
                            {v_wd[k][DW-1:AW+2] | v_wd[k][AW+1:0], v_addr[k], v_re[k], v_we[k]} == '0 ? 64'h0 : 64'h1,
                            64'h0);
                    end
                end
                if (m_busy[k]) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_fire[k] = 1'b1;
                    end
                end else if ((v_re[k] | v_we[k]) && !mrdy[k]) begin
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = m_lat[k];
                    m_addr[k] = v_addr[k];
                    pop_op(k, have, eo);
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL unexpected_op: inst %0d gnt %b addr %h", k, v_gnt[k], v_addr[k]);
                    end else begin
                        chk($sformatf("op_gnt%0d", k), 64'(v_gnt[k]), 64'(eo.gnt));
                        chk($sformatf("op_addr%0d", k), 64'(v_addr[k]), 64'(eo.addr));
                        chk($sformatf("op_rewe%0d", k), 64'({v_re[k], v_we[k]}), 64'({eo.re, eo.we}));
                        if (eo.we) chk($sformatf("op_wdata%0d", k), v_wd[k], eo.wdata);
                    end
                end
            end
        end
    end

    // Evict then fill by requester 1 while requester 0 waits. With the lock
    // enabled the pair stays together; without it requester 0 gets in between.
    task automatic lock_seq(input int k, input logic lock);
        logic [DW-1:0] wd;
        wd = 64'h0123_4567_89AB_CDEF;
        set_req(k, 1, 1'b0, 1'b1, 11'h2A5, wd);
        push_op(k, 4'b0010, 11'h2A5, 1'b0, 1'b1, wd);
        push_rsp(k, 4'b0010, 11'h2A5);
        tick(2);
        set_req(k, 0, 1'b1, 1'b0, 11'h0F0, 64'h0);
        if (lock) begin
            push_op(k, 4'b0010, 11'h015, 1'b1, 1'b0, 64'h0); push_rsp(k, 4'b0010, 11'h015);
            push_op(k, 4'b0001, 11'h0F0, 1'b1, 1'b0, 64'h0); push_rsp(k, 4'b0001, 11'h0F0);
        end else begin
            push_op(k, 4'b0001, 11'h0F0, 1'b1, 1'b0, 64'h0); push_rsp(k, 4'b0001, 11'h0F0);
            push_op(k, 4'b0010, 11'h015, 1'b1, 1'b0, 64'h0); push_rsp(k, 4'b0010, 11'h015);
        end
        wait_rdy(k, 1);
        set_req(k, 1, 1'b1, 1'b0, 11'h015, 64'h0);
        if (lock) begin
            wait_rdy(k, 1); set_req(k, 1, 1'b0, 1'b0, 11'h000, 64'h0);
            wait_rdy(k, 0); set_req(k, 0, 1'b0, 1'b0, 11'h000, 64'h0);
        end else begin
            wait_rdy(k, 0); set_req(k, 0, 1'b0, 1'b0, 11'h000, 64'h0);
            wait_rdy(k, 1); set_req(k, 1, 1'b0, 1'b0, 11'h000, 64'h0);
        end
        tick(2);
    endtask

    initial begin
        logic seen;
        a_re = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_re = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        m_lat[0] = 2;
        m_lat[1] = 2;
        rst = 1'b1;
        tick(3);

        // Reset state of both instances.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_gnt%0d", k), 64'(v_gnt[k]), 64'h0);
            chk($sformatf("rst_en%0d", k), 64'({v_re[k], v_we[k]}), 64'h0);
            chk($sformatf("rst_addr%0d", k), 64'(v_addr[k]), 64'h0);
            chk($sformatf("rst_wdata%0d", k), v_wd[k], 64'h0);
            chk($sformatf("rst_rdy%0d", k), 64'(v_rdy[k]), 64'h0);
        end

        // Contention at reset exit: requester 0 first, then 1 from the HOLD cycle.
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, 1'b0, 11'h040, 64'h0);
        set_req(0, 1, 1'b1, 1'b0, 11'h041, 64'h0);
        push_op(0, 4'b0001, 11'h040, 1'b1, 1'b0, 64'h0); push_rsp(0, 4'b0001, 11'h040);
        push_op(0, 4'b0010, 11'h041, 1'b1, 1'b0, 64'h0); push_rsp(0, 4'b0010, 11'h041);
        rst = 1'b0;
        wait_rdy(0, 0);
        set_req(0, 0, 1'b0, 1'b0, 11'h000, 64'h0);
        @(negedge clk);
        chk("cont_hold_re", 64'(v_re[0]), 64'h0);
        chk("cont_hold_gnt", 64'(v_gnt[0]), 64'h1);
        @(negedge clk);
        chk("cont_busy_re", 64'(v_re[0]), 64'h1);
        chk("cont_busy_gnt", 64'(v_gnt[0]), 64'h2);
        wait_rdy(0, 1);
        set_req(0, 1, 1'b0, 1'b0, 11'h000, 64'h0);
        tick(2);

        // Single read of 0x123: enable appears one cycle after the request.
        set_req(0, 0, 1'b1, 1'b0, 11'h123, 64'h0);
        push_op(0, 4'b0001, 11'h123, 1'b1, 1'b0, 64'h0); push_rsp(0, 4'b0001, 11'h123);
        @(negedge clk);
        chk("rd_cycle0_re", 64'(v_re[0]), 64'h0);
        @(negedge clk);
        chk("rd_cycle1_re", 64'(v_re[0]), 64'h1);
        chk("rd_cycle1_addr", 64'(v_addr[0]), 64'h123);
        wait_rdy(0, 0);
        set_req(0, 0, 1'b0, 1'b0, 11'h000, 64'h0);
        @(negedge clk);
        chk("rd_hold_gnt", 64'(v_gnt[0]), 64'h1);
        chk("rd_hold_re", 64'(v_re[0]), 64'h0);
        @(negedge clk);
        chk("rd_idle_gnt", 64'(v_gnt[0]), 64'h0);
        tick(1);

        // Both enables: write wins.
        set_req(0, 0, 1'b1, 1'b1, 11'h077, 64'hDEAD_BEEF_0000_1111);
        push_op(0, 4'b0001, 11'h077, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1111);
        push_rsp(0, 4'b0001, 11'h077);
        wait_rdy(0, 0);
        set_req(0, 0, 1'b0, 1'b0, 11'h000, 64'h0);
        tick(2);

        // Fairness on the 4-requester instance without lock.
        for (int i = 0; i < 4; i++) set_req(1, i, 1'b1, 1'b0, AW'(11'h300 + i), 64'h0);
        for (int n = 0; n < 5; n++) begin
            push_op(1, 4'(4'b0001 << (n % 4)), AW'(11'h300 + (n % 4)), 1'b1, 1'b0, 64'h0);
            push_rsp(1, 4'(4'b0001 << (n % 4)), AW'(11'h300 + (n % 4)));
        end
        for (int n = 0; n < 5; n++) wait_rdy(1, n % 4);
        for (int i = 0; i < 4; i++) set_req(1, i, 1'b0, 1'b0, 11'h000, 64'h0);
        tick(2);

        // Evict+fill with and without the lock.
        lock_seq(0, 1'b1);
        lock_seq(1, 1'b0);

        // Abort: requester 1 withdraws mid-BUSY, pointer wraps to 0.
        set_req(0, 1, 1'b1, 1'b0, 11'h0AB, 64'h0);
        push_op(0, 4'b0010, 11'h0AB, 1'b1, 1'b0, 64'h0);
        tick(2);
        set_req(0, 1, 1'b0, 1'b0, 11'h000, 64'h0);
        @(negedge clk);
        chk("abort_drop_re", 64'(v_re[0]), 64'h0);
        @(negedge clk);
        chk("abort_idle_gnt", 64'(v_gnt[0]), 64'h0);
        tick(6);
        set_req(0, 0, 1'b1, 1'b0, 11'h100, 64'h0);
        set_req(0, 1, 1'b1, 1'b0, 11'h101, 64'h0);
        push_op(0, 4'b0001, 11'h100, 1'b1, 1'b0, 64'h0); push_rsp(0, 4'b0001, 11'h100);
        push_op(0, 4'b0010, 11'h101, 1'b1, 1'b0, 64'h0); push_rsp(0, 4'b0010, 11'h101);
        wait_rdy(0, 0);
        set_req(0, 0, 1'b0, 1'b0, 11'h000, 64'h0);
        wait_rdy(0, 1);
        set_req(0, 1, 1'b0, 1'b0, 11'h000, 64'h0);
        tick(2);

        // Reset during BUSY; memory completes after reset and is ignored.
        m_lat[0] = 5;
        set_req(0, 0, 1'b1, 1'b0, 11'h155, 64'h0);
        push_op(0, 4'b0001, 11'h155, 1'b1, 1'b0, 64'h0);
        tick(2);
        rst = 1'b1;
        set_req(0, 0, 1'b0, 1'b0, 11'h000, 64'h0);
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_gnt", 64'(v_gnt[0]), 64'h0);
        chk("rstmid_en", 64'({v_re[0], v_we[0]}), 64'h0);
        chk("rstmid_addr", 64'(v_addr[0]), 64'h0);
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mrdy[0]) begin
                seen = 1'b1;
                chk("rstmid_late_rdy", 64'(v_rdy[0]), 64'h0);
            end
        end
        chk("rstmid_late_u_rdy_seen", 64'(seen), 64'h1);
        m_lat[0] = 2;
        tick(2);

        chk("leftover_ops", 64'(opq0.size() + opq1.size()), 64'h0);
        chk("leftover_rsps", 64'(rq0.size() + rq1.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
